// File: rtl/uart_test_check.sv
// uart_test_check
// Receive-side checker for the UART test-data generator. Watches the byte
// strobe from the UART receiver and verifies that bytes follow the +1
// incrementing sequence (0xFF wraps to 0x00). Reports lock status, error and
// byte counts, and a sticky link-loss timeout.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   datain    in   [7:0] received byte, valid when rdsig=1
//   rdsig     in   single-cycle byte-available strobe
//   clr       in   synchronous clear of err_cnt, rx_cnt, timeout
//   locked    out  1 while the checker is locked onto the sequence
//   err_pulse out  one-cycle pulse per mismatch counted while locked
//   err_cnt   out  [15:0] saturating mismatch count (locked only)
//   rx_cnt    out  [15:0] wrapping count of all strobes
//   expected  out  [7:0] next byte value the checker expects
//   timeout   out  sticky link-loss flag
module uart_test_check #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned LOSS_COUNT     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  datain,
  input  logic        rdsig,
  input  logic        clr,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [15:0] rx_cnt,
  output logic [7:0]  expected,
  output logic        timeout
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [31:0] match_cnt;
  logic [31:0] match_nx;
  logic [31:0] miss_cnt;
  logic [31:0] miss_nx;
  logic [19:0] idle_cnt;
  logic [19:0] idle_nx;
  logic [7:0]  expected_nx;
  logic [7:0]  data_inc;
  logic        is_match;
  logic        err_nx;
  logic        tmo_hit;

  assign data_inc = datain + 8'd1;
  assign is_match = (datain == expected);

  // Next-state, sequence tracking and link-loss timer
  always_comb begin
    state_nx    = state;
    match_nx    = match_cnt;
    miss_nx     = miss_cnt;
    idle_nx     = idle_cnt;
    expected_nx = expected;
    err_nx      = 1'b0;
    tmo_hit     = 1'b0;
    if (rdsig) begin
      // A strobe always restarts the silence timer and, whatever the state,
      // the next expected byte follows the byte just received.
      idle_nx     = 20'd0;
      expected_nx = data_inc;
      case (state)
        ST_IDLE: begin
          match_nx = 32'd0;
          state_nx = ST_SYNC;
        end
        ST_SYNC: begin
          if (is_match) begin
            match_nx = match_cnt + 32'd1;
            if ((match_cnt + 32'd1) == LOCK_COUNT) begin
              state_nx = ST_LOCKED;
              miss_nx  = 32'd0;
            end else begin
              state_nx = ST_SYNC;
            end
          end else begin
            match_nx = 32'd0;
          end
        end
        ST_LOCKED: begin
          if (is_match) begin
            miss_nx = 32'd0;
          end else begin
            err_nx  = 1'b1;
            miss_nx = miss_cnt + 32'd1;
            if ((miss_cnt + 32'd1) == LOSS_COUNT) begin
              state_nx = ST_IDLE;
            end else begin
              state_nx = ST_LOCKED;
            end
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end else if (state == ST_IDLE) begin
      idle_nx = 20'd0;
    end else if (idle_cnt == (TIMEOUT_CYCLES - 20'd1)) begin
      // Terminal count without a strobe: the link is considered lost.
      tmo_hit  = 1'b1;
      state_nx = ST_IDLE;
      idle_nx  = 20'd0;
    end else begin
      idle_nx = idle_cnt + 20'd1;
    end
  end

  // State and output registers; clr overrides same-cycle count/flag updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      match_cnt <= 32'd0;
      miss_cnt  <= 32'd0;
      idle_cnt  <= 20'd0;
      expected  <= 8'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= 16'd0;
      rx_cnt    <= 16'd0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      match_cnt <= match_nx;
      miss_cnt  <= miss_nx;
      idle_cnt  <= idle_nx;
      expected  <= expected_nx;
      locked    <= (state_nx == ST_LOCKED);
      err_pulse <= err_nx;
      if (clr) begin
        err_cnt <= 16'd0;
        rx_cnt  <= 16'd0;
        timeout <= 1'b0;
      end else begin
        if (err_nx && (err_cnt != 16'hFFFF)) begin
          err_cnt <= err_cnt + 16'd1;
        end else begin
          err_cnt <= err_cnt;
        end
        if (rdsig) begin
          rx_cnt <= rx_cnt + 16'd1;
        end else begin
          rx_cnt <= rx_cnt;
        end
        if (tmo_hit) begin
          timeout <= 1'b1;
        end else begin
          timeout <= timeout;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_test_check.sv
// Testbench for uart_test_check: table of directed vectors, hand-written
// multi-cycle sequences (wrap, timeout, rdsig at terminal count, saturation,
// asynchronous reset) and randomized traffic checked against a reference model.
module tb_uart_test_check;

  localparam logic [19:0] T_CYC = 20'd100;
  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  datain = 8'd0;
  logic        rdsig = 1'b0;
  logic        clr = 1'b0;
  logic        locked, err_pulse, timeout;
  logic [15:0] err_cnt, rx_cnt;
  logic [7:0]  expected;

  logic [7:0]  datain2 = 8'd0;
  logic        rdsig2 = 1'b0;
  logic        clr2 = 1'b0;
  logic        locked2, err_pulse2, timeout2;
  logic [15:0] err_cnt2, rx_cnt2;
  logic [7:0]  expected2;

  int errors = 0;
  int checks = 0;

  // reference model: "have a reference byte" and "locked" flags plus counts
  bit       m_seeded, m_locked, m_pulse, m_tmo;
  int       m_run, m_misses, m_silence, m_err, m_rx;
  logic [7:0] m_exp;

  typedef struct {
    int          gap;
    logic        rd;
    logic [7:0]  d;
    logic        c;
    logic        lk;
    logic        pl;
    logic [15:0] ec;
    logic [15:0] rc;
    logic [7:0]  ex;
    logic        to;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  uart_test_check #(.TIMEOUT_CYCLES(T_CYC), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS)) dut (
    .clk(clk), .rst_n(rst_n), .datain(datain), .rdsig(rdsig), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .rx_cnt(rx_cnt),
    .expected(expected), .timeout(timeout)
  );

  uart_test_check #(.TIMEOUT_CYCLES(20'd1000), .LOCK_COUNT(4), .LOSS_COUNT(100000)) dut_sat (
    .clk(clk), .rst_n(rst_n), .datain(datain2), .rdsig(rdsig2), .clr(clr2),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2), .rx_cnt(rx_cnt2),
    .expected(expected2), .timeout(timeout2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_seeded = 0; m_locked = 0; m_pulse = 0; m_tmo = 0;
    m_run = 0; m_misses = 0; m_silence = 0; m_err = 0; m_rx = 0; m_exp = 8'd0;
  endtask

  // one clock of the checker's rules, applied to the post-edge view
  task automatic model_step(input logic rd, input logic [7:0] d, input logic c);
    bit good;
    m_pulse = 0;
    if (rd) begin
      good = m_seeded && (d == m_exp);
      m_rx = (m_rx + 1) % 65536;
      if (!m_seeded) begin
        m_seeded = 1;
        m_run = 0;
      end else if (!m_locked) begin
        m_run = good ? m_run + 1 : 0;
        if (m_run == LOCK) begin
          m_locked = 1;
          m_misses = 0;
        end
      end else if (good) begin
        m_misses = 0;
      end else begin
        m_pulse = 1;
        if (m_err < 65535) m_err++;
        m_misses++;
        if (m_misses == LOSS) begin
          m_locked = 0;
          m_seeded = 0;
        end
      end
      m_exp = d + 8'd1;
      m_silence = 0;
    end else if (m_seeded) begin
      if (m_silence == int'(T_CYC) - 1) begin
        m_seeded = 0; m_locked = 0; m_tmo = 1; m_silence = 0;
      end else begin
        m_silence++;
      end
    end
    if (c) begin
      m_err = 0; m_rx = 0; m_tmo = 0;
    end
  endtask

  task automatic cycle(input logic rd, input logic [7:0] d, input logic c);
    @(negedge clk);
    rdsig = rd; datain = d; clr = c;
    model_step(rd, d, c);
    @(posedge clk);
    #1;
    chk("model_locked", locked, m_locked);
    chk("model_err_pulse", err_pulse, m_pulse);
    chk("model_err_cnt", err_cnt, m_err[15:0]);
    chk("model_rx_cnt", rx_cnt, m_rx[15:0]);
    chk("model_expected", expected, m_exp);
    chk("model_timeout", timeout, m_tmo);
  endtask

  function automatic vec_t mk(int gap, logic rd, logic [7:0] d, logic c, logic lk, logic pl,
                              logic [15:0] ec, logic [15:0] rc, logic [7:0] ex, logic to);
    vec_t v;
    v.gap = gap; v.rd = rd; v.d = d; v.c = c; v.lk = lk; v.pl = pl;
    v.ec = ec; v.rc = rc; v.ex = ex; v.to = to;
    return v;
  endfunction

  initial begin
    int dens;
    logic [7:0] dv;
    // lock on 0x10..0x14, single error + resync, clr, loss of lock, reseed
    tbl.push_back(mk(20, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1, 8'h11, 1'b0));
    tbl.push_back(mk(20, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 16'd0, 16'd2, 8'h12, 1'b0));
    tbl.push_back(mk(20, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 16'd0, 16'd3, 8'h13, 1'b0));
    tbl.push_back(mk(20, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 16'd0, 16'd4, 8'h14, 1'b0));
    tbl.push_back(mk(20, 1'b1, 8'h14, 1'b0, 1'b1, 1'b0, 16'd0, 16'd5, 8'h15, 1'b0));
    tbl.push_back(mk(0,  1'b1, 8'h15, 1'b0, 1'b1, 1'b0, 16'd0, 16'd6, 8'h16, 1'b0));
    tbl.push_back(mk(0,  1'b1, 8'h1A, 1'b0, 1'b1, 1'b1, 16'd1, 16'd7, 8'h1B, 1'b0));
    tbl.push_back(mk(0,  1'b1, 8'h1B, 1'b0, 1'b1, 1'b0, 16'd1, 16'd8, 8'h1C, 1'b0));
    tbl.push_back(mk(0,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 8'h1C, 1'b0));
    tbl.push_back(mk(0,  1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1, 8'h01, 1'b0));
    tbl.push_back(mk(0,  1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 16'd2, 16'd2, 8'h81, 1'b0));
    tbl.push_back(mk(0,  1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 16'd3, 16'd3, 8'h34, 1'b0));
    tbl.push_back(mk(0,  1'b1, 8'h50, 1'b0, 1'b0, 1'b0, 16'd3, 16'd4, 8'h51, 1'b0));
    tbl.push_back(mk(0,  1'b1, 8'h60, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 8'h61, 1'b0));

    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {locked, err_pulse, err_cnt, rx_cnt, expected, timeout}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      for (int g = 0; g < tbl[i].gap; g++) cycle(1'b0, 8'h00, 1'b0);
      cycle(tbl[i].rd, tbl[i].d, tbl[i].c);
      chk($sformatf("vec%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("vec%0d_err_pulse", i), err_pulse, tbl[i].pl);
      chk($sformatf("vec%0d_err_cnt", i), err_cnt, tbl[i].ec);
      chk($sformatf("vec%0d_rx_cnt", i), rx_cnt, tbl[i].rc);
      chk($sformatf("vec%0d_expected", i), expected, tbl[i].ex);
      chk($sformatf("vec%0d_timeout", i), timeout, tbl[i].to);
    end

    // wrap: reseed at 0xFA, lock on 0xFE, then 0xFF, 0x00, 0x01
    for (int k = 0; k < 5; k++) cycle(1'b1, 8'hFA + 8'(k), 1'b0);
    chk("wrap_locked_at_fe", locked, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 8'hFF + 8'(k), 1'b0);
      chk("wrap_no_pulse", err_pulse, 1'b0);
    end
    chk("wrap_expected", expected, 8'h02);
    chk("wrap_err_cnt", err_cnt, 16'd0);
    chk("wrap_rx_cnt", rx_cnt, 16'd8);

    // timeout: 99 silent cycles keep lock, the 100th drops it
    repeat (99) cycle(1'b0, 8'h00, 1'b0);
    chk("tmo_pre_locked", locked, 1'b1);
    chk("tmo_pre_flag", timeout, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("tmo_locked", locked, 1'b0);
    chk("tmo_flag", timeout, 1'b1);
    cycle(1'b1, 8'h05, 1'b0);
    chk("tmo_sticky", timeout, 1'b1);
    chk("tmo_reseed_exp", expected, 8'h06);
    cycle(1'b0, 8'h00, 1'b1);
    chk("tmo_clr", timeout, 1'b0);

    // strobe at terminal count wins over timeout
    for (int k = 6; k < 10; k++) cycle(1'b1, 8'(k), 1'b0);
    chk("tc_relock", locked, 1'b1);
    repeat (99) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h0A, 1'b0);
    chk("tc_locked", locked, 1'b1);
    chk("tc_no_timeout", timeout, 1'b0);
    chk("tc_expected", expected, 8'h0B);
    repeat (100) cycle(1'b0, 8'h00, 1'b0);
    chk("tc_later_timeout", timeout, 1'b1);

    // randomized traffic with varying strobe density
    for (int blk = 0; blk < 20; blk++) begin
      case ($urandom_range(0, 2))
        0: dens = 60;
        1: dens = 5;
        default: dens = 1;
      endcase
      for (int k = 0; k < 100; k++) begin
        dv = ($urandom_range(0, 3) != 0) ? m_exp : 8'($urandom_range(0, 255));
        cycle(($urandom_range(0, 99) < dens) ? 1'b1 : 1'b0, dv,
              ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
      end
    end

    // saturation on the second instance: lock, then 65540 back-to-back mismatches
    for (int k = 0; k < 5 + 65540; k++) begin
      @(negedge clk);
      rdsig2 = 1'b1;
      datain2 = (k < 5) ? 8'(k) : 8'h00;
    end
    @(posedge clk);
    #1;
    chk("sat_err_cnt", err_cnt2, 16'hFFFF);
    chk("sat_locked", locked2, 1'b1);
    chk("sat_rx_cnt", rx_cnt2, 16'd9);
    repeat (10) @(posedge clk);
    #1;
    chk("sat_held", err_cnt2, 16'hFFFF);
    chk("sat_pulse", err_pulse2, 1'b1);

    // asynchronous reset in the middle of traffic
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_main", {locked, err_pulse, err_cnt, rx_cnt, expected, timeout}, 64'd0);
    chk("async_rst_sat", {locked2, err_pulse2, err_cnt2, rx_cnt2, expected2, timeout2}, 64'd0);
    @(negedge clk);
    rdsig2 = 1'b0;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 8'h77, 1'b0);
    chk("post_rst_expected", expected, 8'h78);
    chk("post_rst_rx", rx_cnt, 16'd1);
    chk("post_rst_locked", locked, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_test_check.md
# uart_test_check

Receive-side counterpart of the UART test-data generator. Sits after the UART receiver and consumes its byte strobe. It verifies that received bytes form the +1 incrementing sequence (wrapping 0xFF→0x00) the generator sends. It reports lock status, error and byte counts, and link-loss timeout for LEDs or debug readout.

## Interface
- TIMEOUT_CYCLES, 20'd1_000_000: cycles without a byte before the link is declared lost.
- LOCK_COUNT, 4: consecutive in-sequence bytes after the seed byte needed to lock (≥1).
- LOSS_COUNT, 3: consecutive mismatches while locked that drop lock (≥1).
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- datain  input  8  received byte; valid only in a cycle where rdsig=1.
- rdsig  input  1  single-cycle strobe from UART receiver: byte available.
- clr  input  1  synchronous clear of err_cnt, rx_cnt, timeout.
- locked  output  1  1 while FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse per mismatch counted while LOCKED.
- err_cnt  output  16  mismatches counted while LOCKED; saturates at 0xFFFF.
- rx_cnt  output  16  total strobes received; wraps 0xFFFF→0x0000.
- expected  output  8  next byte value the checker expects.
- timeout  output  1  sticky; set on link-loss timeout, cleared only by clr or reset.

## Operation
- Reset: all outputs 0; state IDLE; internal match_cnt, miss_cnt, idle_cnt = 0.
- FSM states: IDLE, SYNC, LOCKED.
- IDLE, on rdsig:
  - expected ← datain+1 (8-bit wrap).
  - match_cnt ← 0.
  - Go to SYNC. No error is counted.
- SYNC, on rdsig with datain==expected:
  - expected ← datain+1; match_cnt++.
  - If match_cnt+1 == LOCK_COUNT, go to LOCKED with miss_cnt ← 0.
- SYNC, on rdsig with a mismatch:
  - Reseed: expected ← datain+1, match_cnt ← 0.
  - Stay in SYNC. No error is counted.
- LOCKED, on rdsig with a match:
  - expected ← datain+1; miss_cnt ← 0.
- LOCKED, on rdsig with a mismatch:
  - err_pulse=1; err_cnt++ (saturating).
  - expected ← datain+1, i.e. resync to the received value.
  - miss_cnt++. If miss_cnt+1 == LOSS_COUNT, go to IDLE.
- rx_cnt increments on every rdsig in every state.
- Timeout:
  - idle_cnt is held at 0 in IDLE and cleared on any rdsig.
  - Otherwise idle_cnt increments each cycle.
  - When idle_cnt reaches TIMEOUT_CYCLES-1 in SYNC or LOCKED: go to IDLE, set timeout=1, idle_cnt ← 0.
  - rdsig in the same cycle as the terminal count: rdsig wins. The byte is processed normally and no timeout occurs.
- clr:
  - Zeroes err_cnt, rx_cnt and timeout in the next cycle.
  - Has priority over a same-cycle increment or timeout set; that cycle's count is dropped.
  - Does not affect the FSM, expected, or err_pulse.
- Reset mid-operation: everything returns to reset values immediately. No partial state is retained.

## Timing
- All outputs are registered and update on the clk edge that samples rdsig=1, i.e. visible the cycle after the strobe.
- err_pulse is high for exactly that one cycle.
- locked rises on the edge sampling the LOCK_COUNT-th matching byte after the seed.
- locked falls on the edge sampling the LOSS_COUNT-th consecutive mismatch, or on the timeout edge.
- Back-to-back rdsig (every cycle) is supported; each strobe is evaluated against the expected value updated by the previous one.
- rdsig high for more than one cycle counts as multiple bytes; upstream guarantees single-cycle strobes.

## Test plan
- Lock: after reset, send bytes 0x10..0x14 one per 20 cycles → locked=1 after 0x14, expected=0x15, rx_cnt=5, err_cnt=0.
- Wrap: locked at 0xFE, send 0xFF, 0x00, 0x01 → no err_pulse, expected=0x02.
- Single error:
  - Locked, expected 0x40, send 0x45, 0x46 → one err_pulse, err_cnt=1, stays locked, expected=0x47.
  - Then clr=1 for one cycle → err_cnt=0, rx_cnt=0, locked still 1.
- Loss: locked, send three non-sequential bytes 0x00, 0x80, 0x33 → err_cnt=3, locked=0 after the third, state IDLE. Next byte 0x50 reseeds with expected=0x51.
- Timeout:
  - TIMEOUT_CYCLES=100, locked, no rdsig for 100 cycles → locked=0, timeout=1.
  - Timeout stays 1 through further bytes until clr.
  - rdsig arriving exactly at cycle 99 → no timeout.
- Saturation/reset:
  - Force 65 540 errors (LOSS_COUNT large) → err_cnt=0xFFFF, held.
  - Assert rst_n=0 mid-sequence → all outputs 0 asynchronously.
